// File: rtl/lookahead_routing_pipe_pkg.sv
// Shared NoC definitions for the lookahead router: port indices, one-hot direction codes, coordinates.
// Used by lookahead_routing_pipe; optional torus routing is selected with LOOKAHEAD_TORUS_EN.
package lookahead_routing_pipe_pkg;

    localparam int PORT_EAST  = 0;
    localparam int PORT_WEST  = 1;
    localparam int PORT_NORTH = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_LOCAL = 4;

    typedef logic [4:0] direction_t;

    localparam direction_t DIR_NONE  = 5'b00000;
    localparam direction_t DIR_EAST  = direction_t'(1 << PORT_EAST);
    localparam direction_t DIR_WEST  = direction_t'(1 << PORT_WEST);
    localparam direction_t DIR_NORTH = direction_t'(1 << PORT_NORTH);
    localparam direction_t DIR_SOUTH = direction_t'(1 << PORT_SOUTH);
    localparam direction_t DIR_LOCAL = direction_t'(1 << PORT_LOCAL);

    typedef struct packed {
        logic [7:0] y;
        logic [7:0] x;
    } xy_t;

endpackage

// File: rtl/lookahead_routing_pipe_if.sv
// Request/result handshake bundle for lookahead_routing_pipe (coordinates packed {y,x}).
// Torus behaviour of the attached block is controlled by LOOKAHEAD_TORUS_EN.
interface lookahead_routing_pipe_if #(
    parameter int XW = 3,
    parameter int YW = 3
) ();
    import lookahead_routing_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XW+YW-1:0]  in_dest;
    direction_t        in_routing;
    logic              out_valid;
    logic              out_ready;
    direction_t        out_routing;
    logic [XW+YW-1:0]  out_dest;
    logic              out_err;

    modport master (
        output in_valid, in_dest, in_routing, out_ready,
        input  in_ready, out_valid, out_routing, out_dest, out_err
    );

    modport slave (
        input  in_valid, in_dest, in_routing, out_ready,
        output in_ready, out_valid, out_routing, out_dest, out_err
    );
endinterface

// File: rtl/lookahead_routing_pipe_route_compute.sv
// Combinational next-hop lookahead: advance position by current hop, then pick dimension-ordered direction.
// Define LOOKAHEAD_TORUS_EN for wrapped positions and shortest-wrap direction choice (ties to East/North).
module route_compute
    import lookahead_routing_pipe_pkg::*;
#(
    parameter int XW = 3,
    parameter int YW = 3,
`ifdef LOOKAHEAD_TORUS_EN
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
`endif
    parameter int ROUTE_MODE = 0
) (
    input  logic [XW+YW-1:0] position,
    input  logic [XW+YW-1:0] dest,
    input  direction_t       routing,
    output direction_t       next_routing,
    output logic             err
);

    logic [XW-1:0] cx, nx, dx;
    logic [YW-1:0] cy, ny, dy;
    direction_t    x_dir, y_dir;

    assign cx = position[XW-1:0];
    assign cy = position[XW+YW-1:XW];
    assign dx = dest[XW-1:0];
    assign dy = dest[XW+YW-1:XW];

`ifdef LOOKAHEAD_TORUS_EN
    int dist_e, dist_w, dist_n, dist_s;

    always_comb begin
        nx = cx;
        ny = cy;
        unique case (routing)
            DIR_EAST:  nx = (cx == XW'(MESH_X - 1)) ? '0 : cx + 1'b1;
            DIR_WEST:  nx = (cx == '0) ? XW'(MESH_X - 1) : cx - 1'b1;
            DIR_NORTH: ny = (cy == YW'(MESH_Y - 1)) ? '0 : cy + 1'b1;
            DIR_SOUTH: ny = (cy == '0) ? YW'(MESH_Y - 1) : cy - 1'b1;
            default: ;
        endcase
    end

    // Eastward/northward wrapped distance; the opposite way is its complement.
    always_comb begin
        dist_e = (int'(dx) - int'(nx) + MESH_X) % MESH_X;
        dist_w = (MESH_X - dist_e) % MESH_X;
        dist_n = (int'(dy) - int'(ny) + MESH_Y) % MESH_Y;
        dist_s = (MESH_Y - dist_n) % MESH_Y;
        x_dir  = DIR_NONE;
        y_dir  = DIR_NONE;
        if (dist_e != 0) x_dir = (dist_e <= dist_w) ? DIR_EAST : DIR_WEST;
        if (dist_n != 0) y_dir = (dist_n <= dist_s) ? DIR_NORTH : DIR_SOUTH;
    end
`else
    always_comb begin
        nx = cx;
        ny = cy;
        unique case (routing)
            DIR_EAST:  nx = cx + 1'b1;
            DIR_WEST:  nx = cx - 1'b1;
            DIR_NORTH: ny = cy + 1'b1;
            DIR_SOUTH: ny = cy - 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        x_dir = DIR_NONE;
        y_dir = DIR_NONE;
        if (nx < dx)      x_dir = DIR_EAST;
        else if (nx > dx) x_dir = DIR_WEST;
        if (ny < dy)      y_dir = DIR_NORTH;
        else if (ny > dy) y_dir = DIR_SOUTH;
    end
`endif

    always_comb begin
        next_routing = DIR_LOCAL;
        err          = 1'b0;
        if (!$onehot(routing)) begin
            err = 1'b1;
        end else if (routing != DIR_LOCAL) begin
            if (ROUTE_MODE == 0) begin
                if (x_dir != DIR_NONE)      next_routing = x_dir;
                else if (y_dir != DIR_NONE) next_routing = y_dir;
            end else begin
                if (y_dir != DIR_NONE)      next_routing = y_dir;
                else if (x_dir != DIR_NONE) next_routing = x_dir;
            end
        end
    end

endmodule

// File: rtl/lookahead_routing_pipe.sv
// Lookahead routing stage: registered result behind a 2-entry (output + skid) buffer, INIT/RUN FSM, request counter.
// Define LOOKAHEAD_TORUS_EN to build the torus variant using MESH_X/MESH_Y.
module lookahead_routing_pipe
    import lookahead_routing_pipe_pkg::*;
#(
    parameter int XW         = 3,
    parameter int YW         = 3,
    parameter int ROUTE_MODE = 0,
    parameter int MESH_X     = 4,
    parameter int MESH_Y     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [XW+YW-1:0]        position,
    lookahead_routing_pipe_if.slave bus,
    output logic [15:0]             route_cnt
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XW+YW-1:0] pos_q, pos_d;
    logic             out_valid_q, out_valid_d;
    direction_t       out_routing_q, out_routing_d;
    logic [XW+YW-1:0] out_dest_q, out_dest_d;
    logic             out_err_q, out_err_d;
    logic             skid_valid_q, skid_valid_d;
    direction_t       skid_routing_q, skid_routing_d;
    logic [XW+YW-1:0] skid_dest_q, skid_dest_d;
    logic             skid_err_q, skid_err_d;
    logic [15:0]      cnt_q, cnt_d;

    logic             in_ready, accept, pop;
    direction_t       next_routing;
    logic             next_err;

    route_compute #(
        .XW(XW),
        .YW(YW),
`ifdef LOOKAHEAD_TORUS_EN
        .MESH_X(MESH_X),
        .MESH_Y(MESH_Y),
`endif
        .ROUTE_MODE(ROUTE_MODE)
    ) u_route (
        .position    (pos_q),
        .dest        (bus.in_dest),
        .routing     (bus.in_routing),
        .next_routing(next_routing),
        .err         (next_err)
    );

    always_comb begin
        state_d        = (state_q == ST_INIT) ? ST_RUN : state_q;
        pos_d          = position;
        out_valid_d    = out_valid_q;
        out_routing_d  = out_routing_q;
        out_dest_d     = out_dest_q;
        out_err_d      = out_err_q;
        skid_valid_d   = skid_valid_q;
        skid_routing_d = skid_routing_q;
        skid_dest_d    = skid_dest_q;
        skid_err_d     = skid_err_q;
        in_ready       = (state_q == ST_RUN) && !skid_valid_q;
        accept         = bus.in_valid && in_ready;
        pop            = out_valid_q && bus.out_ready;
        cnt_d          = (accept && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;

        // Accept implies an empty skid, so a new result goes to the output
        // register whenever that frees up this cycle, else it parks in skid.
        if (accept) begin
            if (!out_valid_q || pop) begin
                out_valid_d   = 1'b1;
                out_routing_d = next_routing;
                out_dest_d    = bus.in_dest;
                out_err_d     = next_err;
            end else begin
                skid_valid_d   = 1'b1;
                skid_routing_d = next_routing;
                skid_dest_d    = bus.in_dest;
                skid_err_d     = next_err;
            end
        end else if (pop) begin
            out_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                out_routing_d = skid_routing_q;
                out_dest_d    = skid_dest_q;
                out_err_d     = skid_err_q;
            end
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            pos_q          <= '0;
            out_valid_q    <= 1'b0;
            out_routing_q  <= '0;
            out_dest_q     <= '0;
            out_err_q      <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_routing_q <= '0;
            skid_dest_q    <= '0;
            skid_err_q     <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            pos_q          <= pos_d;
            out_valid_q    <= out_valid_d;
            out_routing_q  <= out_routing_d;
            out_dest_q     <= out_dest_d;
            out_err_q      <= out_err_d;
            skid_valid_q   <= skid_valid_d;
            skid_routing_q <= skid_routing_d;
            skid_dest_q    <= skid_dest_d;
            skid_err_q     <= skid_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_routing = out_routing_q;
    assign bus.out_dest    = out_dest_q;
    assign bus.out_err     = out_err_q;
    assign route_cnt       = cnt_q;

endmodule

// File: doc/lookahead_routing_pipe.md
LOOKAHEAD_ROUTING_PIPE -- requirements
Module: lookahead_routing_pipe

Interface
REQ-001 SHALL have parameter XW, default 3, x-coordinate width in bits.
REQ-002 SHALL have parameter YW, default 3, y-coordinate width in bits.
REQ-003 SHALL have parameter ROUTE_MODE, default 0, dimension order: 0 = XY (x first), 1 = YX (y first).
REQ-004 SHALL have parameters MESH_X and MESH_Y, default 4 each, mesh extent used only for torus wrap.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 position  in  XW+YW  static router coordinates {y,x}.
REQ-008 in_valid  in  1  header flit lookahead request valid.
REQ-009 in_ready  out  1  block accepts the request.
REQ-010 in_dest  in  XW+YW  destination coordinates {y,x}.
REQ-011 in_routing  in  5  one-hot current-hop direction, bit order {Local,South,North,West,East}.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_routing  out  5  one-hot next-hop direction.
REQ-015 out_dest  out  XW+YW  in_dest passed through alongside the result.
REQ-016 out_err  out  1  in_routing was not one-hot.
REQ-017 route_cnt  out  16  saturating count of accepted requests.

Function
REQ-018 SHALL register the next-hop position each cycle: East x+1, West x-1, North y+1, South y-1, Local unchanged; arithmetic modulo 2^XW / 2^YW.
REQ-019 SHALL select the next-hop position by in_routing, then compute out_routing as follows.
- XY mode: East if nx<dx, West if nx>dx, otherwise North if ny<dy, South if ny>dy, otherwise Local.
- YX mode: the y comparison is made first, then the x comparison.
REQ-020 SHALL set out_routing to Local when in_routing is Local.
REQ-021 SHALL set out_routing to Local and out_err to 1 when in_routing is zero or has more than one bit set.
REQ-022 SHALL use an FSM with states INIT and RUN.
- Reset enters INIT.
- INIT moves to RUN unconditionally one cycle later, after the position register is loaded.
- in_ready SHALL be 0 in INIT.
REQ-023 SHALL present the result registered, one cycle after the in_valid&&in_ready handshake.
REQ-024 SHALL use a 2-entry buffer (output register plus skid register) so that no request is lost while out_ready is low.
- in_ready = RUN && skid register empty.
REQ-025 SHALL hold out_valid, out_routing, out_dest and out_err stable while out_valid&&!out_ready.
REQ-026 On simultaneous input and output handshakes with the skid register empty, SHALL load the new result directly into the output register; throughput is 1 per cycle.
REQ-027 SHALL increment route_cnt on each accepted request and saturate at 16'hFFFF.

Reset
REQ-028 On rst, SHALL take these values:
- out_valid=0, out_routing=0, out_dest=0, out_err=0, route_cnt=0;
- skid register empty, FSM=INIT, in_ready=0.
REQ-029 Reset mid-operation SHALL discard all buffered results without emitting them.

Configuration
REQ-030 With LOOKAHEAD_TORUS_EN defined, SHALL handle next-position and direction as a torus:
- next-position wraps MESH_X-1<->0 and MESH_Y-1<->0;
- direction is chosen by shortest wrapped distance, with ties resolved to East/North.
REQ-031 Without LOOKAHEAD_TORUS_EN, SHALL use plain mesh comparison per REQ-019, and MESH_X/MESH_Y SHALL be unused.

Structure
REQ-032 Direction one-hot constants, port indices, xy_t and direction_t SHALL live in the shared noc package.
REQ-033 Route computation SHALL be a combinational sub-module route_compute; buffering, FSM and counter SHALL stay in the top module.

Verification
REQ-034 Bench SHALL cover XY routing: position (1,1), routing East, dest (3,0) -> out_routing East one cycle after the handshake; dest (2,3) -> North.
REQ-035 Bench SHALL cover YX mode: position (1,1), routing East, dest (3,0) -> South.
REQ-036 Bench SHALL cover backpressure: out_ready=0 for 5 cycles with 3 requests offered -> 2 accepted, in_ready low, outputs held; then release -> results in order.
REQ-037 Bench SHALL cover bad direction: in_routing 5'b00011 -> out_routing Local, out_err=1; in_routing Local -> out_routing Local, out_err=0.
REQ-038 Bench SHALL cover reset during stalled traffic: outputs clear, in_ready=0 for exactly 1 cycle after rst deasserts, route_cnt=0.
REQ-039 Bench SHALL cover torus mode (LOOKAHEAD_TORUS_EN, 4x4 mesh): position (3,0), routing East, dest (1,0) -> East, because next x wraps to 0.
